// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// default timing parameters and the counter-width helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int DEFAULT_HOLD_CYCLES   = 8;
    localparam int DEFAULT_SETTLE_CYCLES = 2;

    // One counter serves both phases, so it must reach the larger of the two counts.
    function automatic int count_width(input int hold_cycles, input int settle_cycles);
        int max_cycles;
        max_cycles = (hold_cycles > settle_cycles) ? hold_cycles : settle_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Clearable up-counter with a terminal-count compare, shared by the HOLD and
// RELEASE phases of the reset sequencer.
module reset_seq_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments and a synchronous
    // reset; the reset is just the highest-priority branch of the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds a downstream domain in reset, lets it settle, then
// enables it; every output comes straight from a flop so dom_rst is glitch-free.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    output logic dom_rst,
    output logic dom_en,
    output logic done,
    output logic busy
);

    localparam int CNT_W = count_width(HOLD_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             tc;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_term;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            HOLD:    if (!req && tc) state_next = RELEASE;
            RELEASE: if (req)        state_next = HOLD;
                     else if (tc)    state_next = RUN;
            RUN:     if (req)        state_next = HOLD;
            default:                 state_next = HOLD;
        endcase
    end

    // The counter restarts on any state change or req, and is parked at zero in RUN.
    assign cnt_clr  = req || (state_next != state) || (state == RUN);
    assign cnt_term = (state == HOLD) ? HOLD_TERM : SETTLE_TERM;

    reset_seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .term  (cnt_term),
        .tc    (tc)
    );

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= HOLD;
            dom_rst <= 1'b1;
            dom_en  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
        end else begin
            state   <= state_next;
            dom_rst <= (state_next == HOLD);
            dom_en  <= (state_next == RUN);
            done    <= (state_next == RUN) && (state != RUN);
            busy    <= (state_next != RUN);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(dom_rst && dom_en));
    assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
    assert property (@(posedge clk) disable iff (!rst_n) done |-> dom_en);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (HOLD_CYCLES=4, SETTLE_CYCLES=2):
// directed timing scenarios plus randomized req/rst_n against a timeline model.
module tb_reset_sequencer;

    localparam int H = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic dom_rst;
    logic dom_en;
    logic done;
    logic busy;
    logic [3:0] obs;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: edges elapsed since the most recent restart event (rst_n=0 or req=1).
    int since = 0;

    reset_sequencer #(
        .HOLD_CYCLES   (H),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .dom_rst (dom_rst),
        .dom_en  (dom_en),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    assign obs = {dom_rst, dom_en, done, busy};

    function automatic logic [3:0] model_out();
        return {since < H, since >= H + S, since == H + S, since < H + S};
    endfunction

    task automatic step(input logic rn, input logic rq);
        rst_n = rn;
        req   = rq;
        @(posedge clk);
        if (!rn || rq) since = 0;
        else if (since < 100000) since++;
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        tests_run++;
        if (obs !== 4'b1001) begin
            tests_failed++;
            $display("FAIL reset_values: got {rst,en,done,busy}=%b expected 1001", obs);
        end
    endtask

    task automatic test_powerup();
        step(1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            tests_run++;
            if (obs !== model_out()) begin
                tests_failed++;
                $display("FAIL powerup edge %0d: got %b expected %b", e, obs, model_out());
            end
            if (e == 4) begin
                tests_run++;
                if (dom_rst !== 1'b0 || dom_en !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL powerup_release edge 4: got rst=%b en=%b expected rst=0 en=0", dom_rst, dom_en);
                end
            end
            if (e == 6) begin
                tests_run++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL powerup_done edge 6: got done=%b busy=%b expected done=1 busy=0", done, busy);
                end
            end
        end
    endtask

    task automatic test_single_req();
        step(1'b0, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            step(1'b1, e == 10);
            tests_run++;
            if (obs !== model_out()) begin
                tests_failed++;
                $display("FAIL single_req edge %0d: got %b expected %b", e, obs, model_out());
            end
        end
    endtask

    task automatic test_held_req();
        int done_seen = 0;
        step(1'b0, 1'b0);
        for (int e = 1; e <= 22; e++) begin
            step(1'b1, e >= 10 && e <= 12);
            if (e > 10 && done === 1'b1) done_seen++;
            tests_run++;
            if (obs !== model_out()) begin
                tests_failed++;
                $display("FAIL held_req edge %0d: got %b expected %b", e, obs, model_out());
            end
        end
        tests_run++;
        if (done_seen != 1) begin
            tests_failed++;
            $display("FAIL held_req_done_count: got %0d pulses expected 1", done_seen);
        end
    endtask

    task automatic test_req_in_release();
        int en_early = 0;
        step(1'b0, 1'b0);
        for (int e = 1; e <= 14; e++) begin
            step(1'b1, e == 5);
            if (e < 11 && dom_en !== 1'b0) en_early++;
            tests_run++;
            if (obs !== model_out()) begin
                tests_failed++;
                $display("FAIL req_in_release edge %0d: got %b expected %b", e, obs, model_out());
            end
        end
        tests_run++;
        if (en_early != 0) begin
            tests_failed++;
            $display("FAIL req_in_release_en: got %0d early enable cycles expected 0", en_early);
        end
    endtask

    task automatic test_reset_mid_run();
        step(1'b0, 1'b0);
        for (int e = 1; e <= 40; e++) begin
            // Reset together with req at 20, then reset during the done cycle at 27.
            step(!(e == 20 || e == 27), e == 20);
            tests_run++;
            if (obs !== model_out()) begin
                tests_failed++;
                $display("FAIL reset_mid_run edge %0d: got %b expected %b", e, obs, model_out());
            end
        end
    endtask

    task automatic test_random();
        int dut_done = 0;
        int ref_done = 0;
        step(1'b0, 1'b0);
        for (int e = 1; e <= 1500; e++) begin
            step($urandom_range(63) != 0, $urandom_range(15) == 0);
            if (done === 1'b1) dut_done++;
            if (since == H + S) ref_done++;
            tests_run++;
            if (obs !== model_out()) begin
                tests_failed++;
                $display("FAIL random edge %0d: got %b expected %b", e, obs, model_out());
            end
        end
        tests_run++;
        if (dut_done != ref_done) begin
            tests_failed++;
            $display("FAIL random_done_count: got %0d expected %0d", dut_done, ref_done);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_single_req();
        test_held_req();
        test_req_in_release();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
